// File: rtl/alu_share_arb_if.sv
// Handshake bundle between two ALU requesters, the shared combinational ALU and
// the alu_share_arb sequencer. The master side is the requesters plus the ALU.
interface alu_share_arb_if #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 6
);
  logic              req0;
  logic [DATA_W-1:0] a0;
  logic [DATA_W-1:0] b0;
  logic [CTRL_W-1:0] ctrl0;
  logic              gnt0;

  logic              req1;
  logic [DATA_W-1:0] a1;
  logic [DATA_W-1:0] b1;
  logic [CTRL_W-1:0] ctrl1;
  logic              gnt1;

  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [CTRL_W-1:0] alu_ctrl;
  logic [DATA_W-1:0] alu_c;
  logic              alu_zero;

  logic              rsp_valid;
  logic              rsp_id;
  logic [DATA_W-1:0] rsp_c;
  logic              rsp_zero;
  logic              busy;

  modport master (
    output req0, a0, b0, ctrl0,
    input  gnt0,
    output req1, a1, b1, ctrl1,
    input  gnt1,
    input  alu_a, alu_b, alu_ctrl,
    output alu_c, alu_zero,
    input  rsp_valid, rsp_id, rsp_c, rsp_zero, busy
  );

  modport slave (
    input  req0, a0, b0, ctrl0,
    output gnt0,
    input  req1, a1, b1, ctrl1,
    output gnt1,
    output alu_a, alu_b, alu_ctrl,
    input  alu_c, alu_zero,
    output rsp_valid, rsp_id, rsp_c, rsp_zero, busy
  );
endinterface

// File: rtl/alu_share_arb.sv
// Round-robin arbiter that time-shares one combinational ALU between two
// requesters: grant + registered operands in EXEC, response captured on exit.
module alu_share_arb #(
  parameter int                DATA_W    = 32,
  parameter int                CTRL_W    = 6,
  parameter logic [CTRL_W-1:0] IDLE_CTRL = '0
) (
  input  logic            clk,
  input  logic            rst,
  alu_share_arb_if.slave  bus
);

  typedef enum logic {IDLE, EXEC} state_t;

  state_t            state_reg, state_next;
  logic              rr_ptr_reg, rr_ptr_next;
  logic              win_id_reg, win_id_next;
  logic [1:0]        gnt_reg, gnt_next;
  logic [DATA_W-1:0] alu_a_reg, alu_a_next;
  logic [DATA_W-1:0] alu_b_reg, alu_b_next;
  logic [CTRL_W-1:0] alu_ctrl_reg, alu_ctrl_next;
  logic              rsp_valid_reg, rsp_valid_next;
  logic              rsp_id_reg, rsp_id_next;
  logic [DATA_W-1:0] rsp_c_reg, rsp_c_next;
  logic              rsp_zero_reg, rsp_zero_next;

  logic [1:0]        req_vec;
  logic [DATA_W-1:0] a_vec    [2];
  logic [DATA_W-1:0] b_vec    [2];
  logic [CTRL_W-1:0] ctrl_vec [2];
  logic              pick;
  logic              issue;

  assign req_vec     = {bus.req1, bus.req0};
  assign a_vec[0]    = bus.a0;
  assign a_vec[1]    = bus.a1;
  assign b_vec[0]    = bus.b0;
  assign b_vec[1]    = bus.b1;
  assign ctrl_vec[0] = bus.ctrl0;
  assign ctrl_vec[1] = bus.ctrl1;

  // The pointer only matters under contention; a lone requester always wins.
  always_comb begin
    if (req_vec == 2'b11) begin
      pick = rr_ptr_reg;
    end else begin
      pick = req_vec[1];
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_gnt
    assign gnt_next[gi] = issue && (pick == 1'(gi));
  end

  always_comb begin
    state_next     = state_reg;
    rr_ptr_next    = rr_ptr_reg;
    win_id_next    = win_id_reg;
    alu_a_next     = alu_a_reg;
    alu_b_next     = alu_b_reg;
    alu_ctrl_next  = alu_ctrl_reg;
    rsp_valid_next = 1'b0;
    rsp_id_next    = rsp_id_reg;
    rsp_c_next     = rsp_c_reg;
    rsp_zero_next  = rsp_zero_reg;
    issue          = 1'b0;

    case (state_reg)
      IDLE: begin
        alu_ctrl_next = IDLE_CTRL;
        if (|req_vec) begin
          issue         = 1'b1;
          win_id_next   = pick;
          alu_a_next    = a_vec[pick];
          alu_b_next    = b_vec[pick];
          alu_ctrl_next = ctrl_vec[pick];
          rr_ptr_next   = ~pick;
          state_next    = EXEC;
        end
      end
      EXEC: begin
        // ALU has settled on the registered operands during this cycle.
        rsp_c_next     = bus.alu_c;
        rsp_zero_next  = bus.alu_zero;
        rsp_id_next    = win_id_reg;
        rsp_valid_next = 1'b1;
        alu_ctrl_next  = IDLE_CTRL;
        state_next     = IDLE;
      end
      default: begin
        alu_ctrl_next = IDLE_CTRL;
        state_next    = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= IDLE;
      rr_ptr_reg    <= 1'b0;
      win_id_reg    <= 1'b0;
      gnt_reg       <= 2'b00;
      alu_a_reg     <= '0;
      alu_b_reg     <= '0;
      alu_ctrl_reg  <= IDLE_CTRL;
      rsp_valid_reg <= 1'b0;
      rsp_id_reg    <= 1'b0;
      rsp_c_reg     <= '0;
      rsp_zero_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      rr_ptr_reg    <= rr_ptr_next;
      win_id_reg    <= win_id_next;
      gnt_reg       <= gnt_next;
      alu_a_reg     <= alu_a_next;
      alu_b_reg     <= alu_b_next;
      alu_ctrl_reg  <= alu_ctrl_next;
      rsp_valid_reg <= rsp_valid_next;
      rsp_id_reg    <= rsp_id_next;
      rsp_c_reg     <= rsp_c_next;
      rsp_zero_reg  <= rsp_zero_next;
    end
  end

  assign bus.gnt0      = gnt_reg[0];
  assign bus.gnt1      = gnt_reg[1];
  assign bus.alu_a     = alu_a_reg;
  assign bus.alu_b     = alu_b_reg;
  assign bus.alu_ctrl  = alu_ctrl_reg;
  assign bus.rsp_valid = rsp_valid_reg;
  assign bus.rsp_id    = rsp_id_reg;
  assign bus.rsp_c     = rsp_c_reg;
  assign bus.rsp_zero  = rsp_zero_reg;
  assign bus.busy      = (state_reg == EXEC);

endmodule
